// File: rtl/lfsr_bist_ctrl_if.sv
// rtl/lfsr_bist_ctrl_if.sv - memory port bundle between the BIST sequencer and the 1024x32 RAM
interface lfsr_bist_ctrl_if;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/lfsr_bist_ctrl.sv
// rtl/lfsr_bist_ctrl.sv - LFSR write/read-compare BIST sequencer for a 1024x32 RAM (option macro: LFSR_BIST_INJECT_EN)
module lfsr_bist_ctrl #(
    parameter int NUM_WORDS = 1023,
    parameter int RD_LAT    = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
`ifdef LFSR_BIST_INJECT_EN
    input  logic             inject_err,
`endif
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [9:0]       first_err_addr,
    lfsr_bist_ctrl_if.master mem
);

    localparam logic [31:0] DATA_SEED = 32'hFFFF_FFFF;
    localparam logic [9:0]  ADDR_SEED = 10'h3FF;
    localparam logic [9:0]  N_LAST    = 10'(NUM_WORDS);
    localparam logic [9:0]  LAT_LAST  = 10'(RD_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_SEED,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    function automatic logic [31:0] data_step(input logic [31:0] v);
        logic [31:0] n;
        n     = {v[30:0], v[31]};
        n[1]  = v[0]  ^ v[31];
        n[2]  = v[1]  ^ v[31];
        n[22] = v[21] ^ v[31];
        return n;
    endfunction

    function automatic logic [9:0] addr_step(input logic [9:0] v);
        logic [9:0] n;
        n    = {v[8:0], v[9]};
        n[3] = v[2] ^ v[9];
        return n;
    endfunction

    state_t      state_q;
    logic [9:0]  cnt_q;
    logic [31:0] data_lfsr_q;
    logic [9:0]  addr_lfsr_q;
    logic [31:0] exp_q;
    logic        mem_en_q;
    logic        mem_we_q;
    logic [9:0]  mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [15:0] err_count_q;
    logic [15:0] err_count_d;
    logic [9:0]  first_err_addr_q;
    logic [9:0]  first_err_addr_d;
    logic        mismatch;
    logic        inj_bit;

    logic [RD_LAT-1:0] dl_vld_q;
    logic [9:0]        dl_addr_q [RD_LAT];
    logic [31:0]       dl_data_q [RD_LAT];

`ifdef LFSR_BIST_INJECT_EN
    assign inj_bit = inject_err;
`else
    assign inj_bit = 1'b0;
`endif

    // Stage 0 captures the read issued in the previous cycle, so the last stage lines up with mem_rdata.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dl_vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dl_addr_q[i] <= '0;
                dl_data_q[i] <= '0;
            end
        end else begin
            dl_vld_q[0]  <= mem_en_q & ~mem_we_q & ~abort;
            dl_addr_q[0] <= mem_addr_q;
            dl_data_q[0] <= exp_q;
            for (int i = 1; i < RD_LAT; i++) begin
                dl_vld_q[i]  <= dl_vld_q[i-1] & ~abort;
                dl_addr_q[i] <= dl_addr_q[i-1];
                dl_data_q[i] <= dl_data_q[i-1];
            end
        end
    end

    always_comb begin
        mismatch         = dl_vld_q[RD_LAT-1] && !abort && (mem.mem_rdata != dl_data_q[RD_LAT-1]);
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        if (mismatch) begin
            if (err_count_q != 16'hFFFF) begin
                err_count_d = err_count_q + 16'd1;
            end
            if (err_count_q == 16'd0) begin
                first_err_addr_d = dl_addr_q[RD_LAT-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            data_lfsr_q      <= DATA_SEED;
            addr_lfsr_q      <= ADDR_SEED;
            exp_q            <= '0;
            mem_en_q         <= 1'b0;
            mem_we_q         <= 1'b0;
            mem_addr_q       <= '0;
            mem_wdata_q      <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
        end else begin
            done_q           <= 1'b0;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            if (abort) begin
                state_q     <= S_IDLE;
                mem_en_q    <= 1'b0;
                mem_we_q    <= 1'b0;
                busy_q      <= 1'b0;
                cnt_q       <= '0;
                data_lfsr_q <= DATA_SEED;
                addr_lfsr_q <= ADDR_SEED;
                if (busy_q) begin
                    pass_q <= 1'b0;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q          <= S_WRITE;
                            busy_q           <= 1'b1;
                            pass_q           <= 1'b0;
                            err_count_q      <= '0;
                            first_err_addr_q <= '0;
                            mem_en_q         <= 1'b1;
                            mem_we_q         <= 1'b1;
                            mem_addr_q       <= addr_lfsr_q;
                            mem_wdata_q      <= data_lfsr_q ^ {31'd0, inj_bit};
                            data_lfsr_q      <= data_step(data_lfsr_q);
                            addr_lfsr_q      <= addr_step(addr_lfsr_q);
                            cnt_q            <= 10'd1;
                        end
                    end
                    S_WRITE: begin
                        if (cnt_q == N_LAST) begin
                            state_q     <= S_SEED;
                            mem_en_q    <= 1'b0;
                            mem_we_q    <= 1'b0;
                            data_lfsr_q <= DATA_SEED;
                            addr_lfsr_q <= ADDR_SEED;
                        end else begin
                            mem_addr_q  <= addr_lfsr_q;
                            mem_wdata_q <= data_lfsr_q;
                            data_lfsr_q <= data_step(data_lfsr_q);
                            addr_lfsr_q <= addr_step(addr_lfsr_q);
                            cnt_q       <= cnt_q + 10'd1;
                        end
                    end
                    S_SEED: begin
                        state_q     <= S_READ;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= addr_lfsr_q;
                        exp_q       <= data_lfsr_q;
                        data_lfsr_q <= data_step(data_lfsr_q);
                        addr_lfsr_q <= addr_step(addr_lfsr_q);
                        cnt_q       <= 10'd1;
                    end
                    S_READ: begin
                        if (cnt_q == N_LAST) begin
                            state_q  <= S_DRAIN;
                            mem_en_q <= 1'b0;
                            cnt_q    <= 10'd1;
                        end else begin
                            mem_addr_q  <= addr_lfsr_q;
                            exp_q       <= data_lfsr_q;
                            data_lfsr_q <= data_step(data_lfsr_q);
                            addr_lfsr_q <= addr_step(addr_lfsr_q);
                            cnt_q       <= cnt_q + 10'd1;
                        end
                    end
                    S_DRAIN: begin
                        // The final compare lands on this same edge, so pass must use the next-state count.
                        if (cnt_q == LAT_LAST) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            pass_q  <= (err_count_d == 16'd0);
                        end else begin
                            cnt_q <= cnt_q + 10'd1;
                        end
                    end
                    S_DONE: begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        cnt_q       <= '0;
                        data_lfsr_q <= DATA_SEED;
                        addr_lfsr_q <= ADDR_SEED;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;
    assign mem.mem_en     = mem_en_q;
    assign mem.mem_we     = mem_we_q;
    assign mem.mem_addr   = mem_addr_q;
    assign mem.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lfsr_bist_ctrl.sv
// tb/tb_lfsr_bist_ctrl.sv - directed checks of lfsr_bist_ctrl against behavioural RAM models
module tb_lfsr_bist_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start_a, abort_a, start_b, abort_b;
    logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [15:0] err_a, err_b;
    logic [9:0]  first_a, first_b;
`ifdef LFSR_BIST_INJECT_EN
    logic        inj_a;
`endif

    int n_cmp;
    int n_bad;
    int fault_a;

    lfsr_bist_ctrl_if mif_a ();
    lfsr_bist_ctrl_if mif_b ();

    always #5 clk = ~clk;

    lfsr_bist_ctrl #(.NUM_WORDS(1023), .RD_LAT(1)) dut_a (
        .clk(clk), .rstn(rstn), .start(start_a), .abort(abort_a),
`ifdef LFSR_BIST_INJECT_EN
        .inject_err(inj_a),
`endif
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_err_addr(first_a), .mem(mif_a)
    );

    lfsr_bist_ctrl #(.NUM_WORDS(4), .RD_LAT(2)) dut_b (
        .clk(clk), .rstn(rstn), .start(start_b), .abort(abort_b),
`ifdef LFSR_BIST_INJECT_EN
        .inject_err(1'b0),
`endif
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_err_addr(first_b), .mem(mif_b)
    );

    // Mode 1: bit 5 of cell 0x3F7 stuck at 1, mode 2: stuck at 0, mode 3: RAM reads all zero.
    function automatic logic [31:0] apply_fault(input int mode, input logic [9:0] a, input logic [31:0] d);
        case (mode)
            1:       return (a == 10'h3F7) ? (d | 32'h20) : d;
            2:       return (a == 10'h3F7) ? (d & ~32'h20) : d;
            3:       return 32'h0;
            default: return d;
        endcase
    endfunction

    logic [31:0] ram_a [1024];
    logic [31:0] ram_b [1024];
    logic [31:0] rd_a_q, rd_b1_q, rd_b2_q;

    always @(posedge clk) begin
        if (mif_a.mem_en && mif_a.mem_we) ram_a[mif_a.mem_addr] <= mif_a.mem_wdata;
        if (mif_a.mem_en && !mif_a.mem_we) rd_a_q <= apply_fault(fault_a, mif_a.mem_addr, ram_a[mif_a.mem_addr]);
        if (mif_b.mem_en && mif_b.mem_we) ram_b[mif_b.mem_addr] <= mif_b.mem_wdata;
        if (mif_b.mem_en && !mif_b.mem_we) rd_b1_q <= ram_b[mif_b.mem_addr];
        rd_b2_q <= rd_b1_q;
    end
    assign mif_a.mem_rdata = rd_a_q;
    assign mif_b.mem_rdata = rd_b2_q;

    typedef struct {
        int          fault;
        int          exp_done;
        logic [15:0] exp_err;
        logic [9:0]  exp_first;
        logic        exp_pass;
    } vec_t;

    vec_t        vecs [4];
    logic [9:0]  wr_addr [2];
    logic [31:0] wr_data [2];
    logic        wr_we [2];
    logic [9:0]  exp_addr [4];
    logic        b_en [17];
    logic        b_we [17];
    logic [9:0]  b_addr [17];
    int          done_cnt, done_at, dc;
    logic        busy13;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_a(output int done_cyc);
        int cyc;
        done_cyc = 0;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        cyc = 1;
        while (done_cyc == 0 && cyc < 4000) begin
            if (cyc <= 2) begin
                wr_addr[cyc-1] = mif_a.mem_addr;
                wr_data[cyc-1] = mif_a.mem_wdata;
                wr_we[cyc-1]   = mif_a.mem_en & mif_a.mem_we;
            end
            if (done_a) done_cyc = cyc;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (done_cyc == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_a_timeout: no done within %0d cycles", cyc);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_cmp = 0; n_bad = 0; fault_a = 0;
        rstn = 1'b0; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
`ifdef LFSR_BIST_INJECT_EN
        inj_a = 1'b0;
`endif
        vecs[0] = '{fault: 0, exp_done: 2049, exp_err: 16'd0,    exp_first: 10'h000, exp_pass: 1'b1};
        vecs[1] = '{fault: 1, exp_done: 2049, exp_err: 16'd0,    exp_first: 10'h000, exp_pass: 1'b1};
        vecs[2] = '{fault: 2, exp_done: 2049, exp_err: 16'd1,    exp_first: 10'h3F7, exp_pass: 1'b0};
        vecs[3] = '{fault: 3, exp_done: 2049, exp_err: 16'd1023, exp_first: 10'h3FF, exp_pass: 1'b0};
        exp_addr[0] = 10'h3FF; exp_addr[1] = 10'h3F7; exp_addr[2] = 10'h3E7; exp_addr[3] = 10'h3C7;

        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_first", first_a, 0);
        chk("rst_mem_en", mif_a.mem_en, 0);
        chk("rst_mem_we", mif_a.mem_we, 0);
        chk("rst_mem_addr", mif_a.mem_addr, 0);
        chk("rst_mem_wdata", mif_a.mem_wdata, 0);
        chk("rst_busy_b", busy_b, 0);

        // start together with abort in IDLE must not launch a test
        start_a = 1'b1; abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; abort_a = 1'b0;
        chk("start_abort_busy", busy_a, 0);
        chk("start_abort_mem_en", mif_a.mem_en, 0);

        for (int i = 0; i < 4; i++) begin
            fault_a = vecs[i].fault;
            run_a(dc);
            chk($sformatf("v%0d_done_cycle", i), dc, vecs[i].exp_done);
            chk($sformatf("v%0d_pass", i), pass_a, vecs[i].exp_pass);
            chk($sformatf("v%0d_err_count", i), err_a, vecs[i].exp_err);
            chk($sformatf("v%0d_first_err", i), first_a, vecs[i].exp_first);
            chk($sformatf("v%0d_busy_at_done", i), busy_a, 1);
            chk($sformatf("v%0d_w1_we", i), wr_we[0], 1);
            chk($sformatf("v%0d_w1_addr", i), wr_addr[0], 10'h3FF);
            chk($sformatf("v%0d_w1_data", i), wr_data[0], 32'hFFFF_FFFF);
            chk($sformatf("v%0d_w2_we", i), wr_we[1], 1);
            chk($sformatf("v%0d_w2_addr", i), wr_addr[1], 10'h3F7);
            chk($sformatf("v%0d_w2_data", i), wr_data[1], 32'hFFBF_FFF9);
            @(negedge clk);
            chk($sformatf("v%0d_busy_after", i), busy_a, 0);
            chk($sformatf("v%0d_done_after", i), done_a, 0);
        end
        fault_a = 0;

        // short instance: 4 writes, SEED gap, 4 reads, drain of 2; a start in cycle 3 is ignored
        done_cnt = 0; done_at = 0; busy13 = 1'b1;
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            b_en[c]   = mif_b.mem_en;
            b_we[c]   = mif_b.mem_we;
            b_addr[c] = mif_b.mem_addr;
            if (done_b) begin
                done_cnt++;
                done_at = c;
            end
            if (c == 13) busy13 = busy_b;
            start_b = (c == 3);
            @(negedge clk);
        end
        start_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("b_wr%0d_en_we", k), {b_en[k+1], b_we[k+1]}, 2'b11);
            chk($sformatf("b_wr%0d_addr", k), b_addr[k+1], exp_addr[k]);
            chk($sformatf("b_rd%0d_en_we", k), {b_en[k+6], b_we[k+6]}, 2'b10);
            chk($sformatf("b_rd%0d_addr", k), b_addr[k+6], exp_addr[k]);
        end
        chk("b_seed_idle", b_en[5], 0);
        chk("b_drain_idle", b_en[10], 0);
        chk("b_done_cycle", done_at, 12);
        chk("b_done_pulses", done_cnt, 1);
        chk("b_pass", pass_b, 1);
        chk("b_err", err_b, 0);
        chk("b_busy_after", busy13, 0);

        // abort during cycle 10 of the write phase
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_busy_before", busy_a, 1);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        chk("abort_mem_en", mif_a.mem_en, 0);
        chk("abort_busy", busy_a, 0);
        done_cnt = 0;
        repeat (20) begin
            if (done_a) done_cnt++;
            @(negedge clk);
        end
        chk("abort_no_done", done_cnt, 0);
        chk("abort_pass", pass_a, 0);
        chk("abort_err_hold", err_a, 0);
        run_a(dc);
        chk("rerun_done_cycle", dc, 2049);
        chk("rerun_pass", pass_a, 1);
        chk("rerun_err", err_a, 0);
        @(negedge clk);

`ifdef LFSR_BIST_INJECT_EN
        inj_a = 1'b1;
        run_a(dc);
        inj_a = 1'b0;
        chk("inj_w1_data", wr_data[0], 32'hFFFF_FFFE);
        chk("inj_err", err_a, 1);
        chk("inj_first", first_a, 10'h3FF);
        chk("inj_pass", pass_a, 0);
        @(negedge clk);
        run_a(dc);
        chk("inj_off_pass", pass_a, 1);
        chk("inj_off_err", err_a, 0);
        @(negedge clk);
`endif

        // asynchronous reset in the middle of a test
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst_busy_before", busy_a, 1);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_busy", busy_a, 0);
        chk("midrst_mem_en", mif_a.mem_en, 0);
        chk("midrst_mem_addr", mif_a.mem_addr, 0);
        chk("midrst_mem_wdata", mif_a.mem_wdata, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("midrst_idle_after", busy_a, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
